// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT state machine
// that drives the memory, PC, instruction-register and ALU control strobes.
// All outputs are combinational from the current state and inputs.
// Optional feature: define RETIRE_COUNT_EN to add the 16-bit retired_cnt
// output, which counts instructions returning to FETCH.
module multicycle_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic [3:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] state,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic [1:0] alu_op,
  output logic       halted
`ifdef RETIRE_COUNT_EN
  ,
  output logic [15:0] retired_cnt
`endif
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b0001;
  localparam logic [3:0] OP_SW    = 4'b0010;
  localparam logic [3:0] OP_ADDI  = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_BNE   = 4'b0101;
  localparam logic [3:0] OP_JMP   = 4'b0110;

  state_t state_q;
  state_t state_d;

  logic is_rtype;
  logic is_lw;
  logic is_sw;
  logic is_addi;
  logic is_beq;
  logic is_bne;
  logic [1:0] rtype_alu_op;

  assign is_rtype = (opcode == OP_RTYPE);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_addi  = (opcode == OP_ADDI);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_bne   = (opcode == OP_BNE);

  // Only func codes 0..3 select a distinct ALU op; anything else falls back to add.
  assign rtype_alu_op = (func[3:2] == 2'b00) ? func[1:0] : 2'b00;

  assign state = state_q;

  // State register; reset abandons any in-flight access and restarts at FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state and control decode; reset masks every output to 0.
  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    alu_src      = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    alu_op       = 2'b00;
    halted       = 1'b0;

    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        if (opcode == OP_JMP) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          state_d  = FETCH;
        end else if (opcode > OP_JMP) begin
          state_d = HALT;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (is_rtype) begin
          alu_op  = rtype_alu_op;
          state_d = WB;
        end else if (is_addi) begin
          alu_src = 1'b1;
          state_d = WB;
        end else if (is_lw || is_sw) begin
          alu_src = 1'b1;
          state_d = MEM;
        end else begin
          alu_op   = 2'b01;
          pc_src   = 2'b01;
          pc_write = (is_beq && zero) || (is_bne && !zero);
          state_d  = FETCH;
        end
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_sw;
        alu_src      = 1'b1;
        if (mem_ready) state_d = is_lw ? WB : FETCH;
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_lw;
        alu_src    = is_addi;
        alu_op     = is_rtype ? rtype_alu_op : 2'b00;
        state_d    = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    if (!rst_n) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 2'b00;
      alu_src      = 1'b0;
      reg_write    = 1'b0;
      mem_to_reg   = 1'b0;
      alu_op       = 2'b00;
      halted       = 1'b0;
    end
  end

`ifdef RETIRE_COUNT_EN
  // Count each return to FETCH from another state; HALT entry never counts.
  always_ff @(posedge clk) begin
    if (!rst_n)                                    retired_cnt <= 16'h0000;
    else if (state_q != FETCH && state_d == FETCH) retired_cnt <= retired_cnt + 16'h0001;
  end
`endif

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 opcode  in  4  instruction-register opcode; stable from DECODE until the instruction returns to FETCH.
REQ-005 func  in  4  instruction-register function field for R-type.
REQ-006 zero  in  1  ALU zero flag from the current EXEC cycle.
REQ-007 mem_ready  in  1  single-port memory completion; qualifies the current mem_req cycle.
REQ-008 state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-009 mem_req, mem_we, mem_addr_sel  out  1 each  memory request, write enable, and address select (0 = PC, 1 = ALU result).
REQ-010 ir_write, pc_write  out  1 each  instruction-register load and PC load strobes.
REQ-011 pc_src  out  2  PC source: 00 = PC+2, 01 = branch target, 10 = jump target.
REQ-012 alu_src, reg_write, mem_to_reg  out  1 each  datapath controls, with the same meaning as the existing decoder outputs.
REQ-013 alu_op  out  2  ALU operation: 00 = add, 01 = sub, 10 = sll, 11 = and.
REQ-014 halted  out  1  high while in HALT.

Function
REQ-015 All outputs SHALL be combinational from state, opcode, func, zero and mem_ready; no output is registered.
REQ-016 Any output not driven by a rule below SHALL be 0.
REQ-017 FETCH: mem_req=1, mem_addr_sel=0; stay in FETCH while mem_ready=0.
REQ-018 FETCH with mem_ready=1: ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
REQ-019 DECODE SHALL last exactly one cycle and branch on opcode as follows.
REQ-020 DECODE, opcode 0110 (jmp): pc_write=1, pc_src=10, then go to FETCH.
REQ-021 DECODE, opcode 0111 to 1111: go to HALT with no strobes asserted.
REQ-022 DECODE, opcode 0000 to 0101: go to EXEC.
REQ-023 EXEC, opcode 0000 (R-type): alu_src=0; func 0000/0001/0010/0011 gives alu_op 00/01/10/11; any other func gives alu_op 00; then go to WB.
REQ-024 EXEC, opcode 0011 (addi): alu_src=1, alu_op=00, then go to WB.
REQ-025 EXEC, opcode 0001/0010 (lw/sw): alu_src=1, alu_op=00, then go to MEM.
REQ-026 EXEC, opcode 0100/0101 (beq/bne): alu_op=01 and pc_src=01.
REQ-027 EXEC, beq/bne: pc_write=1 only if (beq and zero=1) or (bne and zero=0); then go to FETCH.
REQ-028 MEM: mem_req=1, mem_addr_sel=1, mem_we=1 only for sw; alu_src=1 and alu_op=00 held; stay in MEM while mem_ready=0.
REQ-029 MEM with mem_ready=1: lw goes to WB; sw goes to FETCH.
REQ-030 WB: reg_write=1; mem_to_reg=1 for lw, 0 otherwise; R-type alu_op and addi alu_src held as in EXEC; then go to FETCH.
REQ-031 HALT: no strobes asserted, halted=1; the only exit is reset.
REQ-032 Minimum cycles per instruction with zero memory wait: jmp 2, beq/bne 3, R-type/addi/sw 4, lw 5; each mem_ready=0 cycle adds one cycle.
REQ-033 An unreachable state encoding (6 or 7) SHALL go to FETCH on the next edge.

Reset
REQ-034 While rst_n=0 at a rising edge, state SHALL become FETCH and any in-progress access SHALL be abandoned.
REQ-035 While rst_n=0, all strobes SHALL be forced to 0: mem_req, mem_we, ir_write, pc_write, reg_write.
REQ-036 While rst_n=0, pc_src, alu_op, alu_src, mem_to_reg, mem_addr_sel and halted SHALL be 0.
REQ-037 The first instruction fetch SHALL begin in the first cycle after rst_n returns high.

Configuration
REQ-038 With macro RETIRE_COUNT_EN defined, the block SHALL add output port retired_cnt (out, 16 bits).
REQ-039 retired_cnt SHALL reset to 0 and increment on each edge where the state moves into FETCH from a non-FETCH state and rst_n=1.
REQ-040 retired_cnt SHALL wrap from 0xFFFF to 0x0000; HALT entry SHALL NOT count.
REQ-041 Without RETIRE_COUNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-042 addi (opcode 0011), mem_ready tied high -> states 0,1,2,4,0; reg_write=1 only in the WB cycle; alu_src=1 in EXEC and WB.
REQ-043 lw, with mem_ready low for 2 cycles in MEM -> MEM lasts 3 cycles; 7 cycles total; mem_to_reg=1 and reg_write=1 in WB.
REQ-044 beq with zero=1, then bne with zero=1 -> pc_write=1, pc_src=01 in the first EXEC; pc_write=0 in the second.
REQ-045 opcode 1001 -> HALT after DECODE; halted=1 for 20 cycles despite mem_ready toggling; rst_n=0 for one edge -> FETCH.
REQ-046 rst_n=0 asserted in the second MEM wait cycle of an sw -> next state FETCH, mem_we=0 during reset, the sw does not retire.
REQ-047 With RETIRE_COUNT_EN: retired_cnt preset to 0xFFFF by running 65535 jmps, then one jmp -> retired_cnt=0x0000.
